pkt_mem: RTL and testbench
==========================

# pkt_mem

Byte-addressable packet memory that serves the shared memory bus driven by the packet processor (parser, matcher and executor, muxed by the processor). It accepts single-beat 1–4 byte reads and writes in network (big-endian) byte order and answers reads with one-cycle registered latency. A secondary byte-wide host port loads packets in and drains them out, using cycles the processor leaves idle.

## Interface
Parameters:
- DEPTH, 2048 — memory size in bytes; power of two, at least 4.
- ADDR_W, 11 — internal address bits (log2 DEPTH).

Ports:
- clk  in  1 — single clock.
- rst  in  1 — reset. One clock; reset is synchronous and active-low.
- mem_ce_i  in  1 — processor request strobe.
- mem_we_i  in  1 — 1 = write, 0 = read.
- mem_addr_i  in  `ADDR_BUS` — byte address of the first (most significant) byte.
- mem_width_i  in  4 — access size in bytes. Legal values are 1 to 4.
- mem_data_i  in  `DATA_BUS` — write data, right-aligned in the low 8·width bits.
- mem_data_o  out  `DATA_BUS` — read data, right-aligned and zero-extended.
- host_req_i  in  1 — host byte-access request.
- host_we_i  in  1 — host write.
- host_addr_i  in  ADDR_W — host byte address.
- host_data_i  in  8 — host write byte.
- host_gnt_o  out  1 — host request accepted at this edge (registered pulse).
- host_data_o  out  8 — host read byte.
- err_o  out  1 — sticky access-error flag.
- acc_cnt_o  out  16 — count of accepted processor accesses; wraps.

## Operation
- Storage is four byte banks interleaved by addr[1:0]. Any 1–4 byte access touches at most one row per bank, so every access completes in one cycle, including accesses that are not word-aligned.
- Byte order:
  - Byte at addr+k maps to data bits [8(w−1−k)+7 : 8(w−1−k)], where w is the width.
  - On reads, bits above 8w are driven to 0.
  - On writes, bits above 8w are ignored.
- Arbitration:
  - The processor port has absolute priority and is never stalled.
  - A host request is served only in a cycle where mem_ce_i=0. The host holds host_req_i and its fields until host_gnt_o=1.
- Illegal width (0 or 5–15) with mem_ce_i=1:
  - No storage change; the read result is 0.
  - err_o is set, acc_cnt_o is not incremented.
- Address range:
  - Only the low ADDR_W bits of mem_addr_i are decoded.
  - An access whose last byte crosses DEPTH−1 wraps to address 0, unless the bound check described under Configuration is compiled in.
- acc_cnt_o increments by 1 for each accepted, legal processor access.
- Reset clears the following and does not clear RAM contents:
  - mem_data_o = 0, host_data_o = 0, host_gnt_o = 0
  - err_o = 0, acc_cnt_o = 0
  - any pending host grant (the host must re-present its request)
- RAM reads before any write return undefined data. Benches must initialise memory through a port first.

## Timing
- Processor read with mem_ce_i=1, mem_we_i=0 sampled at edge N:
  - mem_data_o is valid after edge N.
  - It holds until the next accepted processor read; processor writes and idle cycles do not change it.
- Processor write sampled at edge N commits at edge N. A read issued at N+1 returns the new data.
- A write followed by a read of the same address in back-to-back cycles is legal. No bypass is needed because the write commits before the read samples.
- Host access:
  - A request is sampled at edge N when mem_ce_i=0. host_gnt_o=1 for the one cycle after edge N.
  - For a read, host_data_o is valid in that same cycle and holds until the next host read.
  - If mem_ce_i=1 at edge N, no grant is given and the request retries the following cycle.
- Host and processor never access in the same cycle, so no RAM port conflict exists.
- When rst=0 at edge N, all outputs take their reset values after edge N, regardless of any in-flight request.

## Configuration
- PKT_MEM_BOUND_CHECK_EN defined:
  - Any processor access with addr+width−1 ≥ DEPTH, or with nonzero address bits above ADDR_W, is rejected.
  - A rejected access makes no storage change, returns 0 on a read, and sets err_o. acc_cnt_o is not incremented.
- PKT_MEM_BOUND_CHECK_EN undefined:
  - No range logic is built; addresses wrap modulo DEPTH.
  - err_o is set only by an illegal width.

## Test plan
- Host writes bytes 0x45,0x00,0x00,0x54 to addresses 0x10–0x13; processor then reads width 4 at 0x10 → mem_data_o=0x45000054 one cycle later; acc_cnt_o=1.
- Processor writes width 2, data 0xFFFFBEEF at 0x21 (unaligned), then reads width 1 at 0x21 and at 0x22 → 0x000000BE, then 0x000000EF.
- Host read request held at 0x21 while mem_ce_i=1 for 3 cycles → host_gnt_o stays 0; grant comes the cycle after mem_ce_i drops, with host_data_o=0xBE.
- Processor access with width 0, then width 5 → err_o=1 after the first, memory unchanged, acc_cnt_o unchanged; err_o clears only when rst=0.
- With PKT_MEM_BOUND_CHECK_EN, read width 4 at DEPTH−2 → mem_data_o=0, err_o=1. Without it, the same read returns bytes DEPTH−2, DEPTH−1, 0, 1.
- Assert rst=0 during a host-pending cycle after read data is returned → mem_data_o=0, host_gnt_o=0, acc_cnt_o=0 next cycle; prior RAM data is still readable afterwards.

Source files
------------

// File: rtl/pkt_mem.sv
// pkt_mem: byte-addressable packet memory built from four interleaved byte banks, with a priority processor port and an idle-cycle host port.
// Optional feature: define PKT_MEM_BOUND_CHECK_EN to reject processor accesses that run past DEPTH-1.

`ifndef ADDR_BUS
`define ADDR_BUS 31:0
`endif
`ifndef DATA_BUS
`define DATA_BUS 31:0
`endif

module pkt_mem #(
  parameter int DEPTH  = 2048,
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_ce_i,
  input  logic              mem_we_i,
  input  logic [`ADDR_BUS]  mem_addr_i,
  input  logic [3:0]        mem_width_i,
  input  logic [`DATA_BUS]  mem_data_i,
  output logic [`DATA_BUS]  mem_data_o,
  input  logic              host_req_i,
  input  logic              host_we_i,
  input  logic [ADDR_W-1:0] host_addr_i,
  input  logic [7:0]        host_data_i,
  output logic              host_gnt_o,
  output logic [7:0]        host_data_o,
  output logic              err_o,
  output logic [15:0]       acc_cnt_o
);

  localparam int ROWS  = DEPTH / 4;
  localparam int ROW_W = ADDR_W - 2;

  logic [7:0]       bank_mem [4][ROWS];
  logic [ADDR_W-1:0] addr_low;
  logic             width_ok;
  logic             in_range;
  logic             proc_ok;
  logic             host_go;
  logic [1:0]       lane_off [4];
  logic [1:0]       lane_sh  [4];
  logic             lane_act [4];
  logic [ROW_W-1:0] lane_row [4];
  logic [31:0]      rd_data;

  assign addr_low = mem_addr_i[ADDR_W-1:0];
  assign width_ok = (mem_width_i != 4'd0) && (mem_width_i <= 4'd4);
  assign host_go  = host_req_i && !mem_ce_i;
  assign proc_ok  = mem_ce_i && width_ok && in_range;

`ifdef PKT_MEM_BOUND_CHECK_EN
  localparam int AW = $bits(mem_addr_i);
  localparam int EW = AW + 1;
  logic [AW:0] end_addr;

  // The extra carry bit keeps an access that overflows the address bus from looking in range.
  assign end_addr = {1'b0, mem_addr_i} + EW'(mem_width_i) - EW'(1);
  assign in_range = end_addr < EW'(DEPTH);
`else
  logic unused_addr_hi;

  assign unused_addr_hi = ^mem_addr_i[$bits(mem_addr_i)-1:ADDR_W];
  assign in_range       = 1'b1;
`endif

  // Bank b holds the byte at offset k = (b - addr[1:0]) mod 4; that byte sits in data lane w-1-k.
  always_comb begin
    for (int b = 0; b < 4; b++) begin
      lane_off[b] = 2'(b) - addr_low[1:0];
      lane_act[b] = {2'b00, lane_off[b]} < mem_width_i;
      lane_sh[b]  = mem_width_i[1:0] - 2'd1 - lane_off[b];
      lane_row[b] = ROW_W'((addr_low + ADDR_W'(lane_off[b])) >> 2);
    end
  end

  always_comb begin
    rd_data = '0;
    if (width_ok && in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (lane_act[b]) begin
          rd_data[{lane_sh[b], 3'b000} +: 8] = bank_mem[b][lane_row[b]];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < 4; b++) begin
        if (proc_ok && mem_we_i && lane_act[b]) begin
          bank_mem[b][lane_row[b]] <= mem_data_i[{lane_sh[b], 3'b000} +: 8];
        end
      end
      if (host_go && host_we_i) begin
        bank_mem[host_addr_i[1:0]][host_addr_i[ADDR_W-1:2]] <= host_data_i;
      end
    end
  end

  // Read data holds across writes and idle cycles; rejected reads still update it, to zero.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_data_o  <= '0;
      host_data_o <= '0;
      host_gnt_o  <= 1'b0;
      err_o       <= 1'b0;
      acc_cnt_o   <= '0;
    end else begin
      host_gnt_o <= host_go;
      if (host_go && !host_we_i) begin
        host_data_o <= bank_mem[host_addr_i[1:0]][host_addr_i[ADDR_W-1:2]];
      end
      if (mem_ce_i && !mem_we_i) begin
        mem_data_o <= rd_data;
      end
      if (mem_ce_i && !proc_ok) begin
        err_o <= 1'b1;
      end
      if (proc_ok) begin
        acc_cnt_o <= acc_cnt_o + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_pkt_mem.sv
// tb_pkt_mem: directed bench for pkt_mem; a byte-array model is compared against the DUT every cycle.
// Builds with or without PKT_MEM_BOUND_CHECK_EN; literal expectations follow the same macro.

module tb_pkt_mem;

  localparam int DEPTH  = 2048;
  localparam int ADDR_W = 11;

  logic              clk = 1'b0;
  logic              rst;
  logic              mem_ce_i;
  logic              mem_we_i;
  logic [31:0]       mem_addr_i;
  logic [3:0]        mem_width_i;
  logic [31:0]       mem_data_i;
  logic [31:0]       mem_data_o;
  logic              host_req_i;
  logic              host_we_i;
  logic [ADDR_W-1:0] host_addr_i;
  logic [7:0]        host_data_i;
  logic              host_gnt_o;
  logic [7:0]        host_data_o;
  logic              err_o;
  logic [15:0]       acc_cnt_o;

  int   checks = 0;
  int   errors = 0;
  logic chk_en = 1'b0;

  logic [7:0]  model_mem [DEPTH];
  logic [31:0] exp_data;
  logic        exp_gnt;
  logic [7:0]  exp_hdata;
  logic        exp_err;
  logic [15:0] exp_cnt;

  pkt_mem #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .mem_ce_i(mem_ce_i), .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i),
    .mem_width_i(mem_width_i), .mem_data_i(mem_data_i), .mem_data_o(mem_data_o),
    .host_req_i(host_req_i), .host_we_i(host_we_i), .host_addr_i(host_addr_i),
    .host_data_i(host_data_i), .host_gnt_o(host_gnt_o), .host_data_o(host_data_o),
    .err_o(err_o), .acc_cnt_o(acc_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h required 0x%08h", name, act, req);
    end
  endtask

  function automatic int wrap_idx(input logic [31:0] a, input int k);
    return int'((longint'(a) + longint'(k)) % longint'(DEPTH));
  endfunction

  function automatic logic model_ok(input logic [31:0] a, input logic [3:0] w);
    if (w == 4'd0 || w > 4'd4) return 1'b0;
`ifdef PKT_MEM_BOUND_CHECK_EN
    return (longint'(a) + longint'(w) - 1) < longint'(DEPTH);
`else
    return 1'b1;
`endif
  endfunction

  // Byte at addr+k lands in lane w-1-k; everything above 8*w stays zero.
  function automatic logic [31:0] model_read(input logic [31:0] a, input logic [3:0] w);
    logic [31:0] r = '0;
    for (int k = 0; k < int'(w); k++) r[8*(int'(w)-1-k) +: 8] = model_mem[wrap_idx(a, k)];
    return r;
  endfunction

  always @(posedge clk) begin
    if (!rst) begin
      exp_data  <= '0;
      exp_gnt   <= 1'b0;
      exp_hdata <= '0;
      exp_err   <= 1'b0;
      exp_cnt   <= '0;
    end else begin
      exp_gnt <= host_req_i && !mem_ce_i;
      if (host_req_i && !mem_ce_i) begin
        if (host_we_i) model_mem[int'(host_addr_i)] <= host_data_i;
        else           exp_hdata <= model_mem[int'(host_addr_i)];
      end
      if (mem_ce_i) begin
        if (model_ok(mem_addr_i, mem_width_i)) exp_cnt <= exp_cnt + 16'd1;
        else                                   exp_err <= 1'b1;
        if (!mem_we_i) begin
          exp_data <= model_ok(mem_addr_i, mem_width_i) ? model_read(mem_addr_i, mem_width_i) : 32'd0;
        end else if (model_ok(mem_addr_i, mem_width_i)) begin
          for (int k = 0; k < 4; k++) begin
            if (k < int'(mem_width_i))
              model_mem[wrap_idx(mem_addr_i, k)] <= mem_data_i[8*(int'(mem_width_i)-1-k) +: 8];
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      checkOutput("mem_data_o", mem_data_o, exp_data);
      checkOutput("host_gnt_o", 32'(host_gnt_o), 32'(exp_gnt));
      checkOutput("host_data_o", 32'(host_data_o), 32'(exp_hdata));
      checkOutput("err_o", 32'(err_o), 32'(exp_err));
      checkOutput("acc_cnt_o", 32'(acc_cnt_o), 32'(exp_cnt));
    end
  end

  task automatic applyStimulus(input logic ce, input logic we, input logic [31:0] addr,
                               input logic [3:0] w, input logic [31:0] data,
                               input logic hreq, input logic hwe, input logic [ADDR_W-1:0] haddr,
                               input logic [7:0] hdata, input logic r);
    mem_ce_i    = ce;
    mem_we_i    = we;
    mem_addr_i  = addr;
    mem_width_i = w;
    mem_data_i  = data;
    host_req_i  = hreq;
    host_we_i   = hwe;
    host_addr_i = haddr;
    host_data_i = hdata;
    rst         = r;
    @(posedge clk);
    #1;
  endtask

  task automatic proc(input logic we, input logic [31:0] addr, input logic [3:0] w, input logic [31:0] data);
    applyStimulus(1'b1, we, addr, w, data, 1'b0, 1'b0, '0, 8'h00, 1'b1);
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 32'd0, 4'd0, 32'd0, 1'b0, 1'b0, '0, 8'h00, 1'b1);
  endtask

  // Host holds its request until granted, bounded so a dead grant cannot hang the run.
  task automatic host_write(input logic [ADDR_W-1:0] haddr, input logic [7:0] hdata);
    logic got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      applyStimulus(1'b0, 1'b0, 32'd0, 4'd0, 32'd0, 1'b1, 1'b1, haddr, hdata, 1'b1);
      got = host_gnt_o;
    end
    checkOutput("host_write_gnt", 32'(got), 32'd1);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    applyStimulus(1'b0, 1'b0, 32'd0, 4'd0, 32'd0, 1'b0, 1'b0, '0, 8'h00, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'd0, 4'd0, 32'd0, 1'b0, 1'b0, '0, 8'h00, 1'b0);
    chk_en = 1'b1;
    checkOutput("reset_data", mem_data_o, 32'd0);
    checkOutput("reset_cnt", 32'(acc_cnt_o), 32'd0);
    checkOutput("reset_err", 32'(err_o), 32'd0);
    checkOutput("reset_gnt", 32'(host_gnt_o), 32'd0);

    host_write(11'h010, 8'h45);
    host_write(11'h011, 8'h00);
    host_write(11'h012, 8'h00);
    host_write(11'h013, 8'h54);
    idle();
    proc(1'b0, 32'h10, 4'd4, 32'd0);
    checkOutput("tp1_word", mem_data_o, 32'h45000054);
    checkOutput("tp1_cnt", 32'(acc_cnt_o), 32'd1);

    proc(1'b1, 32'h21, 4'd2, 32'hFFFFBEEF);
    checkOutput("tp2_hold_after_write", mem_data_o, 32'h45000054);
    proc(1'b0, 32'h21, 4'd1, 32'd0);
    checkOutput("tp2_byte21", mem_data_o, 32'h000000BE);
    proc(1'b0, 32'h22, 4'd1, 32'd0);
    checkOutput("tp2_byte22", mem_data_o, 32'h000000EF);
    proc(1'b0, 32'h20, 4'd4, 32'd0);
    checkOutput("tp2_unaligned_word", mem_data_o & 32'h00FFFF00, 32'h00BEEF00);

    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 32'h22, 4'd1, 32'd0, 1'b1, 1'b0, 11'h021, 8'h00, 1'b1);
      checkOutput("tp3_no_gnt", 32'(host_gnt_o), 32'd0);
    end
    applyStimulus(1'b0, 1'b0, 32'd0, 4'd0, 32'd0, 1'b1, 1'b0, 11'h021, 8'h00, 1'b1);
    checkOutput("tp3_gnt", 32'(host_gnt_o), 32'd1);
    checkOutput("tp3_hdata", 32'(host_data_o), 32'h000000BE);
    idle();
    checkOutput("tp3_gnt_pulse", 32'(host_gnt_o), 32'd0);
    checkOutput("tp3_cnt", 32'(acc_cnt_o), 32'd8);

    proc(1'b0, 32'h10, 4'd0, 32'd0);
    checkOutput("tp4_err_w0", 32'(err_o), 32'd1);
    checkOutput("tp4_data_w0", mem_data_o, 32'd0);
    proc(1'b1, 32'h10, 4'd5, 32'hDEADBEEF);
    checkOutput("tp4_cnt", 32'(acc_cnt_o), 32'd8);
    proc(1'b0, 32'h10, 4'd4, 32'd0);
    checkOutput("tp4_mem_intact", mem_data_o, 32'h45000054);
    checkOutput("tp4_err_sticky", 32'(err_o), 32'd1);

    host_write(11'h7FE, 8'h11);
    host_write(11'h7FF, 8'h22);
    host_write(11'h000, 8'h33);
    host_write(11'h001, 8'h44);
    proc(1'b0, 32'(DEPTH - 2), 4'd4, 32'd0);
`ifdef PKT_MEM_BOUND_CHECK_EN
    checkOutput("tp5_edge_read", mem_data_o, 32'd0);
`else
    checkOutput("tp5_edge_read", mem_data_o, 32'h11223344);
`endif
    proc(1'b0, 32'h0001_0010, 4'd1, 32'd0);
`ifdef PKT_MEM_BOUND_CHECK_EN
    checkOutput("tp5_high_bits", mem_data_o, 32'd0);
    checkOutput("tp5_cnt", 32'(acc_cnt_o), 32'd9);
`else
    checkOutput("tp5_high_bits", mem_data_o, 32'h00000045);
    checkOutput("tp5_cnt", 32'(acc_cnt_o), 32'd11);
`endif

    proc(1'b0, 32'h10, 4'd4, 32'd0);
    applyStimulus(1'b1, 1'b0, 32'h21, 4'd1, 32'd0, 1'b1, 1'b0, 11'h013, 8'h00, 1'b0);
    checkOutput("tp6_data", mem_data_o, 32'd0);
    checkOutput("tp6_gnt", 32'(host_gnt_o), 32'd0);
    checkOutput("tp6_cnt", 32'(acc_cnt_o), 32'd0);
    checkOutput("tp6_err", 32'(err_o), 32'd0);
    idle();
    proc(1'b0, 32'h10, 4'd4, 32'd0);
    checkOutput("tp6_ram_kept", mem_data_o, 32'h45000054);
    checkOutput("tp6_cnt_restart", 32'(acc_cnt_o), 32'd1);
    idle();

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
